// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0..T2, execute T3..T7, plus RESET and HALT.
// Control outputs decode from the current state and the IR opcode field.
module control_unit #(
    parameter int ALU_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    output logic             Pout,
    output logic             MDROut,
    output logic             Cout,
    output logic             ZLOout,
    output logic             BAout,
    output logic             Rout,
    output logic             Pen,
    output logic             MARen,
    output logic             MDRen,
    output logic             IRen,
    output logic             Yen,
    output logic             Zen,
    output logic             Rin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Read,
    output logic             Write,
    output logic [ALU_W-1:0] alu_control,
    output logic             run
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_INC4 = 5'b01111;

    state_t      state;
    logic [4:0]  op;
    logic [26:0] unused_ir;
    logic        is_rtype, is_addi, is_ldi, is_ld, is_st, is_halt, is_mem;

    assign op        = ir[31:27];
    assign unused_ir = ir[26:0];

    assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_addi  = (op == OP_ADDI);
    assign is_ldi   = (op == OP_LDI);
    assign is_ld    = (op == OP_LD);
    assign is_st    = (op == OP_ST);
    assign is_halt  = (op == OP_HALT);
    assign is_mem   = is_ld || is_st;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                // Anything outside the defined set falls through as nop.
                S_T2: begin
                    if (is_halt)
                        state <= S_HALT;
                    else if (is_rtype || is_addi || is_ldi || is_mem)
                        state <= S_T3;
                    else
                        state <= S_T0;
                end
                S_T3:    state <= S_T4;
                S_T4:    state <= S_T5;
                S_T5:    state <= is_mem ? S_T6 : S_T0;
                S_T6:    state <= S_T7;
                S_T7:    state <= S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        Pout = 1'b0; MDROut = 1'b0; Cout = 1'b0; ZLOout = 1'b0; BAout = 1'b0; Rout = 1'b0;
        Pen = 1'b0; MARen = 1'b0; MDRen = 1'b0; IRen = 1'b0; Yen = 1'b0; Zen = 1'b0; Rin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Read = 1'b0; Write = 1'b0;
        alu_control = '0;
        run = 1'b0;
        case (state)
            S_T0: begin
                run = 1'b1; Pout = 1'b1; MARen = 1'b1; Zen = 1'b1;
                alu_control = ALU_W'(ALU_INC4);
            end
            S_T1: begin
                run = 1'b1; ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1;
            end
            S_T2: begin
                run = 1'b1; MDROut = 1'b1; IRen = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (is_rtype || is_addi) begin
                    Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
                end else if (is_ldi || is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Yen = 1'b1;
                end
            end
            S_T4: begin
                run = 1'b1;
                if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Zen = 1'b1;
                    alu_control = ALU_W'(op);
                end else if (is_addi || is_ldi || is_mem) begin
                    Cout = 1'b1; Zen = 1'b1;
                    alu_control = ALU_W'(ALU_ADD);
                end
            end
            S_T5: begin
                run = 1'b1;
                if (is_mem) begin
                    ZLOout = 1'b1; MARen = 1'b1;
                end else if (is_rtype || is_addi || is_ldi) begin
                    ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T6: begin
                run = 1'b1;
                if (is_ld) begin
                    Read = 1'b1; MDRen = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1;
                end
            end
            S_T7: begin
                run = 1'b1;
                if (is_ld) begin
                    MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed per-cycle vector table plus random instruction
// stream compared against a per-instruction micro-step model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic Pout, MDROut, Cout, ZLOout, BAout, Rout;
    logic Pen, MARen, MDRen, IRen, Yen, Zen, Rin;
    logic Gra, Grb, Grc, Read, Write, run;
    logic [4:0] alu_control;
    logic [23:0] obs;

    always #5 clk = ~clk;

    control_unit #(.ALU_W(5)) dut (
        .clk(clk), .clr(clr), .ir(ir),
        .Pout(Pout), .MDROut(MDROut), .Cout(Cout), .ZLOout(ZLOout), .BAout(BAout), .Rout(Rout),
        .Pen(Pen), .MARen(MARen), .MDRen(MDRen), .IRen(IRen), .Yen(Yen), .Zen(Zen), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
        .alu_control(alu_control), .run(run)
    );

    assign obs = {Pout, MDROut, Cout, ZLOout, BAout, Rout,
                  Pen, MARen, MDRen, IRen, Yen, Zen, Rin,
                  Gra, Grb, Grc, Read, Write, run, alu_control};

    localparam logic [23:0] POUT = 24'h800000, MDROUT = 24'h400000, COUT = 24'h200000;
    localparam logic [23:0] ZLOOUT = 24'h100000, BAOUT = 24'h080000, ROUT = 24'h040000;
    localparam logic [23:0] PEN = 24'h020000, MAREN = 24'h010000, MDREN = 24'h008000;
    localparam logic [23:0] IREN = 24'h004000, YEN = 24'h002000, ZEN = 24'h001000;
    localparam logic [23:0] RIN = 24'h000800, GRA = 24'h000400, GRB = 24'h000200;
    localparam logic [23:0] GRC = 24'h000100, READ = 24'h000080, WRITE = 24'h000040;
    localparam logic [23:0] RUN = 24'h000020;

    localparam logic [23:0] S_T0  = RUN | POUT | MAREN | ZEN | 24'h0F;
    localparam logic [23:0] S_T1  = RUN | ZLOOUT | PEN | READ | MDREN;
    localparam logic [23:0] S_T2  = RUN | MDROUT | IREN;
    localparam logic [23:0] S_RT3 = RUN | GRB | ROUT | YEN;
    localparam logic [23:0] S_BT3 = RUN | GRB | BAOUT | YEN;
    localparam logic [23:0] S_RT4 = RUN | GRC | ROUT | ZEN;
    localparam logic [23:0] S_CT4 = RUN | COUT | ZEN | 24'h03;
    localparam logic [23:0] S_WB  = RUN | ZLOOUT | GRA | RIN;
    localparam logic [23:0] S_MA5 = RUN | ZLOOUT | MAREN;
    localparam logic [23:0] S_LD6 = RUN | READ | MDREN;
    localparam logic [23:0] S_LD7 = RUN | MDROUT | GRA | RIN;
    localparam logic [23:0] S_ST6 = RUN | GRA | ROUT | MDREN;
    localparam logic [23:0] S_ST7 = RUN | WRITE;

    localparam logic [31:0] I_ADD = 32'h19890000, I_LD = 32'h00800055, I_ST = 32'h10800087;
    localparam logic [31:0] I_HALT = 32'hD8000000, I_UNDEF = 32'hF8000000;

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic add_vec(input logic c, input logic [31:0] i, input logic [23:0] e);
        vec_t v;
        v.clr = c; v.ir = i; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_invariants(input string tag);
        check({tag, "_rw_excl"}, {23'b0, Read & Write}, 24'h0);
        check({tag, "_bus_src"}, {23'b0, ($countones(obs[23:18]) > 1)}, 24'h0);
    endtask

    // Expected output sequence of one instruction, one entry per cycle.
    task automatic build_expected(input logic [4:0] op);
        exp_q.delete();
        exp_q.push_back(S_T0);
        exp_q.push_back(S_T1);
        exp_q.push_back(S_T2);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                exp_q.push_back(S_RT3);
                exp_q.push_back(S_RT4 | {19'b0, op});
                exp_q.push_back(S_WB);
            end
            5'd12: begin exp_q.push_back(S_RT3); exp_q.push_back(S_CT4); exp_q.push_back(S_WB); end
            5'd1:  begin exp_q.push_back(S_BT3); exp_q.push_back(S_CT4); exp_q.push_back(S_WB); end
            5'd0:  begin
                exp_q.push_back(S_BT3); exp_q.push_back(S_CT4); exp_q.push_back(S_MA5);
                exp_q.push_back(S_LD6); exp_q.push_back(S_LD7);
            end
            5'd2:  begin
                exp_q.push_back(S_BT3); exp_q.push_back(S_CT4); exp_q.push_back(S_MA5);
                exp_q.push_back(S_ST6); exp_q.push_back(S_ST7);
            end
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [31:0] instr, input int unsigned n);
        build_expected(instr[31:27]);
        for (int unsigned c = 0; c < exp_q.size(); c++) begin
            // Fetch cycles must not depend on ir, so feed junk there.
            ir = (c < 2) ? $urandom : instr;
            #1;
            check($sformatf("rnd[%0d] op=%b cyc%0d", n, instr[31:27], c), obs, exp_q[c]);
            check_invariants($sformatf("rnd[%0d]", n));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] instr;
        logic [4:0]  defined [9];

        clr = 1'b1;
        ir  = '0;
        @(posedge clk); @(posedge clk); #1;

        add_vec(1, I_ADD, 24'h0);
        add_vec(0, I_ADD, 24'h0);
        add_vec(0, I_ADD, S_T0); add_vec(0, I_ADD, S_T1); add_vec(0, I_ADD, S_T2);
        add_vec(0, I_ADD, S_RT3); add_vec(0, I_ADD, S_RT4 | 24'h03); add_vec(0, I_ADD, S_WB);
        add_vec(0, I_LD, S_T0); add_vec(0, I_LD, S_T1); add_vec(0, I_LD, S_T2);
        add_vec(0, I_LD, S_BT3); add_vec(0, I_LD, S_CT4); add_vec(0, I_LD, S_MA5);
        add_vec(0, I_LD, S_LD6); add_vec(0, I_LD, S_LD7);
        add_vec(0, I_ST, S_T0); add_vec(0, I_ST, S_T1); add_vec(0, I_ST, S_T2);
        add_vec(0, I_ST, S_BT3); add_vec(0, I_ST, S_CT4); add_vec(0, I_ST, S_MA5);
        add_vec(0, I_ST, S_ST6); add_vec(0, I_ST, S_ST7);
        add_vec(0, I_UNDEF, S_T0); add_vec(0, I_UNDEF, S_T1); add_vec(0, I_UNDEF, S_T2);
        add_vec(0, I_HALT, S_T0); add_vec(0, I_HALT, S_T1); add_vec(0, I_HALT, S_T2);
        for (int i = 0; i < 10; i++) add_vec(0, I_HALT, 24'h0);
        add_vec(1, I_HALT, 24'h0);
        add_vec(0, I_LD, 24'h0);
        add_vec(0, I_LD, S_T0); add_vec(0, I_LD, S_T1); add_vec(0, I_LD, S_T2);
        add_vec(0, I_LD, S_BT3); add_vec(0, I_LD, S_CT4); add_vec(0, I_LD, S_MA5);
        add_vec(1, I_LD, S_LD6);
        add_vec(0, I_LD, 24'h0);
        add_vec(0, I_ADD, S_T0);

        foreach (tbl[k]) begin
            clr = tbl[k].clr;
            ir  = tbl[k].ir;
            #1;
            check($sformatf("tbl[%0d]", k), obs, tbl[k].exp);
            check_invariants($sformatf("tbl[%0d]", k));
            @(posedge clk); #1;
        end

        clr = 1'b1;
        @(posedge clk); #1;
        check("reset_state", obs, 24'h0);
        clr = 1'b0;
        @(posedge clk); #1;

        defined = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd26};
        for (int unsigned n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do op = 5'($urandom); while (op == 5'd27);
            end else begin
                op = defined[$urandom_range(0, 8)];
            end
            instr = {op, 27'($urandom)};
            run_instr(instr, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter ALU_W, default 5, width of alu_control.
REQ-002 SHALL have one clock and one reset: clk in 1 (all state changes on rising edge); clr in 1 (reset, synchronous, active-high).
REQ-003 SHALL have input ir in 32: current IR contents from the datapath; opcode is ir[31:27].
REQ-004 SHALL have outputs Pout, MDROut, Cout, ZLOout, BAout, Rout, out 1 each: bus-source selects.
REQ-005 SHALL have outputs Pen, MARen, MDRen, IRen, Yen, Zen, Rin, out 1 each: register load enables.
REQ-006 SHALL have outputs Gra, Grb, Grc, out 1 each: register-field selects for the select/encode logic.
REQ-007 SHALL have outputs Read, Write, out 1 each: memory strobes.
REQ-008 SHALL have output alu_control, out ALU_W: ALU operation code.
REQ-009 SHALL have output run, out 1: high while executing, low in RESET and HALT.

Function
REQ-010 SHALL be a Moore FSM with states RESET, T0..T7 and HALT; outputs decode from the state register and ir[31:27] only.
REQ-011 SHALL deassert every output not listed for the current state, and drive alu_control=0 unless a code is listed.
REQ-012 Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, nop=11010, halt=11011; any other opcode SHALL execute as nop.
REQ-013 ALU codes: ADD=00011, SUB=00100, AND=00101, OR=00110, INC4=01111 (Z = bus + 4).
REQ-014 Fetch: T0 = Pout, MARen, alu_control=INC4, Zen; T1 = ZLOout, Pen, Read, MDRen; T2 = MDROut, IRen.
REQ-015 add/sub/and/or: T3 = Grb, Rout, Yen; T4 = Grc, Rout, Zen, alu_control=opcode; T5 = ZLOout, Gra, Rin; then T0.
REQ-016 addi: T3 = Grb, Rout, Yen; T4 = Cout, ADD, Zen; T5 = ZLOout, Gra, Rin; then T0.
REQ-017 ldi: T3 = Grb, BAout, Yen; T4 = Cout, ADD, Zen; T5 = ZLOout, Gra, Rin; then T0.
REQ-018 ld: T3 = Grb, BAout, Yen; T4 = Cout, ADD, Zen; T5 = ZLOout, MARen; T6 = Read, MDRen; T7 = MDROut, Gra, Rin; then T0.
REQ-019 st: T3 to T5 as ld; T6 = Gra, Rout, MDRen (Read low); T7 = Write; then T0.
REQ-020 nop/undefined: T2 -> T0. halt: T2 -> HALT. HALT SHALL hold with all outputs 0 until clr.
REQ-021 Instruction length in cycles: nop 3; R-type, addi, ldi 6; ld, st 8. No idle cycle between instructions.
REQ-022 Opcode SHALL be decoded only in T3..T7 and in the T2 exit decision; ir SHALL be ignored in T0/T1.
REQ-023 Read and Write SHALL never be high in the same cycle; at most one bus-source select SHALL be high per cycle.

Reset
REQ-024 clr high at a rising edge SHALL force RESET from any state, including mid-instruction and HALT.
REQ-025 In RESET all outputs SHALL be 0 and run=0; the first edge with clr low SHALL move RESET -> T0.
REQ-026 run SHALL be 1 in T0..T7.

Verification
REQ-027 clr high 2 cycles, then low, ir=0x19890000 (add r3,r1,r2) -> T0..T5 in 6 cycles; T4 alu_control=00011 with Grc, Rout, Zen; T5 Gra, Rin; then T0.
REQ-028 ir=0x00800055 (ld r1,0x55(r0)) -> 8 cycles; T5 ZLOout+MARen; T6 Read+MDRen; T7 MDROut+Gra+Rin.
REQ-029 ir=0x10800087 (st 0x87(r0),r1) -> T6 Gra+Rout+MDRen with Read=0; T7 Write=1 alone; Read/Write never coincide.
REQ-030 ir=0xD8000000 (halt) -> HALT after T2, run=0, all outputs 0 for 10 cycles; clr pulse -> RESET, then T0.
REQ-031 ir=0xF8000000 (undefined) -> behaves as nop, T2 -> T0.
REQ-032 clr asserted during T6 of ld -> next cycle RESET with all outputs 0; Rin never asserted.
